// File: rtl/preprocess_issue_ctrl_pkg.sv
// Shared types for the CORDIC x/y pre-process issue stage: packet layout and FSM states.
// Field ranges are inclusive bit positions within a 108-bit instruction packet.
package preprocess_issue_ctrl_pkg;

  localparam int PKT_W  = 108;
  localparam int TAG_W  = 8;
  localparam int TAG_HI = 107;
  localparam int TAG_LO = 100;
  localparam int OPC_HI = 99;
  localparam int OPC_LO = 96;
  localparam int Z_HI   = 95;
  localparam int Z_LO   = 64;
  localparam int Y_HI   = 63;
  localparam int Y_LO   = 32;
  localparam int X_HI   = 31;
  localparam int X_LO   = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/preprocess_issue_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter, zero latency; search starts one past the last grant.
// No backpressure of its own: the caller decides when the grant is taken and updates i_last.
module preprocess_issue_ctrl_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic w_found;

  // Offset k walks the ring from i_last+1; the first requester hit wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_req[i] && (i == (int'(i_last) + k) % NUM_REQ)) begin
          w_found   = 1'b1;
          o_gnt[i]  = 1'b1;
          o_gnt_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/preprocess_issue_ctrl.sv
// Issue controller: grants one packet, holds it on the pre-processor, waits for a tag-matched
// done (earliest out_valid 3 cycles after grant), then holds the result until out_ready.
module preprocess_issue_ctrl
  import preprocess_issue_ctrl_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int MAX_WAIT = 64,
  localparam int SRC_W    = $clog2(NUM_REQ),
  localparam int WC_W     = $clog2(MAX_WAIT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] i_req_packet,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [PKT_W-1:0]         o_pp_packet,
  input  logic [PKT_W-1:0]         i_pp_result,
  input  logic                     i_pp_done,
  output logic                     o_out_valid,
  output logic [PKT_W-1:0]         o_out_packet,
  output logic [SRC_W-1:0]         o_out_src,
  input  logic                     i_out_ready,
  output logic                     o_busy,
  output logic                     o_timeout_err
);

  state_t             r_state, w_next_state;
  logic [SRC_W-1:0]   r_rr_ptr, r_src, r_out_src;
  logic [WC_W-1:0]    r_wait_cnt;
  logic [TAG_W-1:0]   r_iss_tag;
  logic [PKT_W-1:0]   r_pp_packet, r_out_packet;
  logic               r_out_valid, r_timeout_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic [PKT_W-1:0]   w_sel_pkt;
  logic               w_any, w_done, w_expire;

  preprocess_issue_ctrl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (i_req_valid),
    .i_last    (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_pkt = i_req_packet[i*PKT_W +: PKT_W];
    end
  end

  assign w_any = |i_req_valid;
  // The first WAIT cycle (count 0) is skipped so a done left over from the previous packet cannot complete this one.
  assign w_done   = (r_wait_cnt != '0) && i_pp_done && (i_pp_result[TAG_HI:TAG_LO] == r_iss_tag);
  assign w_expire = (r_wait_cnt == WC_W'(MAX_WAIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_WAIT;
      S_WAIT:  if (w_done) w_next_state = S_OUT;
               else if (w_expire) w_next_state = S_IDLE;
      S_OUT:   if (i_out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if (r_state == S_IDLE) o_req_ready = w_gnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr      <= SRC_W'(NUM_REQ - 1);
      r_src         <= '0;
      r_out_src     <= '0;
      r_wait_cnt    <= '0;
      r_iss_tag     <= '0;
      r_pp_packet   <= '0;
      r_out_packet  <= '0;
      r_out_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_pp_packet <= w_sel_pkt;
            r_iss_tag   <= w_sel_pkt[TAG_HI:TAG_LO];
            r_src       <= w_gnt_idx;
            r_rr_ptr    <= w_gnt_idx;
            r_wait_cnt  <= '0;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_done) begin
            r_out_packet <= i_pp_result;
            r_out_src    <= r_src;
            r_out_valid  <= 1'b1;
          end else if (w_expire) begin
            r_timeout_err <= 1'b1;
          end
        end
        S_OUT: begin
          if (i_out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_pp_packet   = r_pp_packet;
  assign o_out_valid   = r_out_valid;
  assign o_out_packet  = r_out_packet;
  assign o_out_src     = r_out_src;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule
